// File: rtl/fp_pipe_issue_ctrl_pkg.sv
// Shared constants and types for the FP add/sub issue controller slice.
// Optional perf counters are enabled with `FP_ISSUE_PERF_CNT_EN.
package fp_pipe_issue_ctrl_pkg;

  localparam int unsigned FP_PIPE_DEPTH = 3;
  localparam int unsigned FP_RD_W       = 5;

  typedef logic [FP_RD_W-1:0] rd_idx_t;

  typedef struct packed {
    logic       valid;
    rd_idx_t    rs1;
    rd_idx_t    rs2;
    logic [1:0] rs_fp;
    rd_idx_t    rd;
  } exe_p_mux_bus_type;

  // One spare bit beyond 0..depth so an overflow is observable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/fp_pipe_issue_ctrl_if.sv
// Issue / writeback / unit-control bundle of the FP add/sub issue controller.
interface fp_pipe_issue_ctrl_if #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RD_W  = 5,
  parameter int unsigned CNT_W = 32
);
  logic                        issue_valid;
  logic                        issue_ready;
  logic [RD_W-1:0]             issue_rs1;
  logic [RD_W-1:0]             issue_rs2;
  logic [1:0]                  issue_rs_fp;
  logic                        flush;
  logic                        drain_req;
  logic                        drained;
  logic                        wb_ready;
  logic                        wb_valid;
  logic                        unit_en;
  logic [DEPTH-1:0]            unit_clear;
  logic                        unit_p_start;
  logic                        p_result;
  logic [DEPTH-1:0][RD_W-1:0]  uu_rd;
  logic [DEPTH-1:0]            uu_reg_write;
  logic [DEPTH-1:0]            uu_FP_reg_write;
  logic                        busy;
  logic                        proto_err;
  logic [CNT_W-1:0]            stall_haz_cnt;
  logic [CNT_W-1:0]            stall_wb_cnt;

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs_fp, flush, drain_req,
           wb_ready, p_result, uu_rd, uu_reg_write, uu_FP_reg_write,
    output issue_ready, drained, wb_valid, unit_en, unit_clear, unit_p_start,
           busy, proto_err, stall_haz_cnt, stall_wb_cnt
  );

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs_fp, flush, drain_req,
           wb_ready, p_result, uu_rd, uu_reg_write, uu_FP_reg_write,
    input  issue_ready, drained, wb_valid, unit_en, unit_clear, unit_p_start,
           busy, proto_err, stall_haz_cnt, stall_wb_cnt
  );
endinterface

// File: rtl/fp_pipe_issue_ctrl_hazard_cmp.sv
// Combinational RAW check of one source operand against every unit stage.
module fp_hazard_cmp #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned RD_W  = 5
) (
  input  logic [RD_W-1:0]            rs,
  input  logic                       rs_fp,
  input  logic [DEPTH-1:0][RD_W-1:0] uu_rd,
  input  logic [DEPTH-1:0]           uu_reg_write,
  input  logic [DEPTH-1:0]           uu_FP_reg_write,
  output logic                       hit
);

  // x0 is hard-wired in the int file, so it never creates a dependency.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rs == uu_rd[i] &&
          (rs_fp ? uu_FP_reg_write[i] : (uu_reg_write[i] && rs != '0)))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/fp_pipe_issue_ctrl.sv
// Issue-side controller for the 3-stage pipelined FP add/sub unit.
// `FP_ISSUE_PERF_CNT_EN adds saturating stall counters.
module fp_pipe_issue_ctrl
  import fp_pipe_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FP_PIPE_DEPTH,
  parameter int unsigned RD_W  = FP_RD_W,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  fp_pipe_issue_ctrl_if.slave pif
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             hit_rs1;
  logic             hit_rs2;
  logic             hazard;
  logic             unit_en;
  logic             issue_ready;
  logic             p_start;
  logic             wb_fire;
  logic             proto_err_q;
  logic [CNT_W-1:0] haz_cnt;
  logic [CNT_W-1:0] wb_cnt;

  fp_hazard_cmp #(.DEPTH(DEPTH), .RD_W(RD_W)) u_haz_rs1 (
    .rs              (pif.issue_rs1),
    .rs_fp           (pif.issue_rs_fp[0]),
    .uu_rd           (pif.uu_rd),
    .uu_reg_write    (pif.uu_reg_write),
    .uu_FP_reg_write (pif.uu_FP_reg_write),
    .hit             (hit_rs1)
  );

  fp_hazard_cmp #(.DEPTH(DEPTH), .RD_W(RD_W)) u_haz_rs2 (
    .rs              (pif.issue_rs2),
    .rs_fp           (pif.issue_rs_fp[1]),
    .uu_rd           (pif.uu_rd),
    .uu_reg_write    (pif.uu_reg_write),
    .uu_FP_reg_write (pif.uu_FP_reg_write),
    .hit             (hit_rs2)
  );

  // The whole unit freezes while its finished result is not taken.
  always_comb begin
    hazard      = hit_rs1 | hit_rs2;
    unit_en     = ~(pif.p_result & ~pif.wb_ready);
    issue_ready = unit_en & ~hazard & ~pif.flush & ~pif.drain_req;
    p_start     = pif.issue_valid & issue_ready;
    wb_fire     = pif.p_result & pif.wb_ready;
  end

  always_comb begin
    count_nxt = count;
    if (pif.flush)
      count_nxt = '0;
    else if (p_start && !wb_fire)
      count_nxt = count + 1'b1;
    else if (!p_start && wb_fire && count != '0)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else
      count <= count_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      proto_err_q <= 1'b0;
    else if (pif.p_result && count == '0 && !pif.flush)
      proto_err_q <= 1'b1;
  end

`ifdef FP_ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      haz_cnt <= '0;
      wb_cnt  <= '0;
    end else begin
      if (pif.issue_valid && hazard && unit_en && haz_cnt != '1)
        haz_cnt <= haz_cnt + 1'b1;
      if (!unit_en && wb_cnt != '1)
        wb_cnt <= wb_cnt + 1'b1;
    end
  end
`else
  always_comb begin
    haz_cnt = '0;
    wb_cnt  = '0;
  end
`endif

  always_comb begin
    pif.issue_ready   = issue_ready;
    pif.unit_p_start  = p_start;
    pif.unit_en       = unit_en;
    pif.unit_clear    = {DEPTH{pif.flush}};
    pif.wb_valid      = pif.p_result;
    pif.busy          = (count != '0);
    pif.drained       = pif.drain_req & (count == '0);
    pif.proto_err     = proto_err_q;
    pif.stall_haz_cnt = haz_cnt;
    pif.stall_wb_cnt  = wb_cnt;
  end

  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count <= CW'(DEPTH));

endmodule

// File: tb/tb_fp_pipe_issue_ctrl.sv
// Scoreboard bench: a behavioural FP unit plus rule-level reference model feed
// an expectation queue that a separate monitor checks every cycle.
module tb_fp_pipe_issue_ctrl;

  localparam int unsigned D = 3;

  typedef struct {
    logic        issue_ready;
    logic        p_start;
    logic        unit_en;
    logic [2:0]  clear;
    logic        wb_valid;
    logic        busy;
    logic        drained;
    logic        proto_err;
    logic [31:0] haz;
    logic [31:0] wbs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_pipe_issue_ctrl_if #(.DEPTH(3), .RD_W(5), .CNT_W(32)) pif ();

  fp_pipe_issue_ctrl #(.DEPTH(3), .RD_W(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif.slave)
  );

  // Behavioural unit: a 3-deep shift of in-flight ops, frozen by en.
  logic       st_v  [D];
  logic [4:0] st_rd [D];
  logic       st_rw [D];
  logic       st_fw [D];
  logic       force_pres = 1'b0;

  int          cnt_m;
  logic        proto_m;
  logic [31:0] haz_m;
  logic [31:0] wbs_m;
  logic        last_ps;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic src_haz(input logic [4:0] rs, input logic fp);
    for (int i = 0; i < D; i++)
      if (st_v[i] && rs == st_rd[i] && (fp ? st_fw[i] : (st_rw[i] && rs != 5'd0)))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      st_v[i] = 1'b0; st_rd[i] = '0; st_rw[i] = 1'b0; st_fw[i] = 1'b0;
    end
    cnt_m = 0; proto_m = 1'b0; haz_m = '0; wbs_m = '0; force_pres = 1'b0;
  endtask

  task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [1:0] fp, input logic [4:0] rd, input logic rw,
                      input logic fw, input logic fl, input logic dr, input logic wr);
    exp_t e;
    logic pres, en, haz, fire;
    @(negedge clk);
    pif.issue_valid = v;  pif.issue_rs1 = r1; pif.issue_rs2 = r2;
    pif.issue_rs_fp = fp; pif.flush = fl;     pif.drain_req = dr;
    pif.wb_ready    = wr;
    for (int i = 0; i < D; i++) begin
      pif.uu_rd[i]           = st_rd[i];
      pif.uu_reg_write[i]    = st_v[i] & st_rw[i];
      pif.uu_FP_reg_write[i] = st_v[i] & st_fw[i];
    end
    pres = st_v[D-1] | force_pres;
    pif.p_result = pres;
    en   = !(pres && !wr);
    haz  = src_haz(r1, fp[0]) || src_haz(r2, fp[1]);
    fire = pres && wr;
    e.unit_en     = en;
    e.issue_ready = en && !haz && !fl && !dr;
    e.p_start     = v && e.issue_ready;
    e.clear       = fl ? 3'b111 : 3'b000;
    e.wb_valid    = pres;
    e.busy        = (cnt_m != 0);
    e.drained     = dr && (cnt_m == 0);
    e.proto_err   = proto_m;
`ifdef FP_ISSUE_PERF_CNT_EN
    e.haz = haz_m; e.wbs = wbs_m;
`else
    e.haz = '0;    e.wbs = '0;
`endif
    exp_q.push_back(e);
    last_ps = e.p_start;
    @(posedge clk);
    if (rst) begin
      if (pres && cnt_m == 0 && !fl) proto_m = 1'b1;
      cnt_m = fl ? 0 : cnt_m + int'(e.p_start) - int'(fire);
      if (v && haz && en && haz_m != '1) haz_m = haz_m + 1;
      if (!en && wbs_m != '1) wbs_m = wbs_m + 1;
      if (fl) begin
        for (int i = 0; i < D; i++) st_v[i] = 1'b0;
      end else if (en) begin
        for (int i = D - 1; i > 0; i--) begin
          st_v[i] = st_v[i-1]; st_rd[i] = st_rd[i-1];
          st_rw[i] = st_rw[i-1]; st_fw[i] = st_fw[i-1];
        end
        st_v[0] = e.p_start; st_rd[0] = rd; st_rw[0] = rw; st_fw[0] = fw;
      end
    end
  endtask

  task automatic idle(input int n, input logic wr);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, wr);
  endtask

  // Monitor: the controller presents a full output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_ready", 32'(pif.issue_ready),  32'(e.issue_ready));
        chk("p_start",     32'(pif.unit_p_start), 32'(e.p_start));
        chk("unit_en",     32'(pif.unit_en),      32'(e.unit_en));
        chk("unit_clear",  32'(pif.unit_clear),   32'(e.clear));
        chk("wb_valid",    32'(pif.wb_valid),     32'(e.wb_valid));
        chk("busy",        32'(pif.busy),         32'(e.busy));
        chk("drained",     32'(pif.drained),      32'(e.drained));
        chk("proto_err",   32'(pif.proto_err),    32'(e.proto_err));
        chk("stall_haz",   pif.stall_haz_cnt,     e.haz);
        chk("stall_wb",    pif.stall_wb_cnt,      e.wbs);
      end
    end
  end

  initial begin
    int tries;
    model_reset();
    last_ps = 1'b0;
    idle(3, 1'b1);
    #2 rst = 1'b1;

    // single op, immediate writeback
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(5, 1'b1);

    // FP RAW: consumer of f5 waits for the producer to leave the pipe
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tries = 0;
    do begin
      step(1'b1, 5'd5, 5'd3, 2'b11, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tries++;
    end while (!last_ps && tries < 8);
    chk("raw_stall_cycles", 32'(tries), 32'd4);
    idle(5, 1'b1);

    // x0 never stalls; same index across files never stalls
    step(1'b1, 5'd1, 5'd2, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("x0_no_stall", 32'(last_ps), 32'd1);
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd9, 5'd9, 2'b00, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("cross_file_no_stall", 32'(last_ps), 32'd1);
    idle(5, 1'b1);

    // three back-to-back, writeback blocked, then released
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd20, 5'd21, 2'b11, 5'(10 + i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd22, 5'd23, 2'b11, 5'd14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b1);

    // flush with two in flight and a competing issue
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // drain with two in flight, then a spurious result
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'd3, 5'd4, 2'b11, 5'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    force_pres = 1'b1;
    step(1'b0, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    force_pres = 1'b0;
    idle(3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic fpb, fl;
      fpb = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 19) == 0);
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), ~fpb, fpb, fl,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
    end

    // asynchronous reset between edges with work in flight
    step(1'b1, 5'd30, 5'd31, 2'b11, 5'd29, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("async_busy", 32'(pif.busy), 32'd0);
    chk("async_proto_err", 32'(pif.proto_err), 32'd0);
    chk("async_stall_haz", pif.stall_haz_cnt, 32'd0);
    idle(2, 1'b1);
    #2 rst = 1'b1;
    step(1'b1, 5'd1, 5'd2, 2'b11, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(5, 1'b1);

    @(negedge clk);
    #5;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
